// File: rtl/seqtest.sv
// Clocked stimulus/compare harness: drives comp_in exhaustively or from a Galois LFSR,
// compares a pipelined DUT output against a delayed reference and reports through ports.
module seqtest #(
    parameter string       name         = "unnamed",
    parameter int unsigned inbits       = 4,
    parameter int unsigned outbits      = 4,
    parameter int unsigned latency      = 0,
    parameter int unsigned mode         = 0,
    parameter int unsigned seed         = 1,
    parameter int unsigned count        = 0,
    parameter int unsigned stop_on_fail = 1,
    parameter int unsigned errbits      = 16,
    parameter int unsigned verbose      = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [inbits-1:0]  comp_in,
    input  logic [outbits-1:0] verify,
    input  logic [outbits-1:0] comp_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [errbits-1:0] err_count,
    output logic [inbits-1:0]  fail_in
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

    // Maximal-length feedback masks for a right-shifting Galois LFSR, bit (t-1) per tap t.
    function automatic logic [23:0] tap_mask(input int unsigned w);
        case (w)
            1:       tap_mask = 24'h000001;
            2:       tap_mask = 24'h000003;
            3:       tap_mask = 24'h000006;
            4:       tap_mask = 24'h00000C;
            5:       tap_mask = 24'h000014;
            6:       tap_mask = 24'h000030;
            7:       tap_mask = 24'h000060;
            8:       tap_mask = 24'h0000B8;
            9:       tap_mask = 24'h000110;
            10:      tap_mask = 24'h000240;
            11:      tap_mask = 24'h000500;
            12:      tap_mask = 24'h000829;
            13:      tap_mask = 24'h00100D;
            14:      tap_mask = 24'h002015;
            15:      tap_mask = 24'h006000;
            16:      tap_mask = 24'h00D008;
            17:      tap_mask = 24'h012000;
            18:      tap_mask = 24'h020400;
            19:      tap_mask = 24'h040023;
            20:      tap_mask = 24'h090000;
            21:      tap_mask = 24'h140000;
            22:      tap_mask = 24'h300000;
            23:      tap_mask = 24'h420000;
            24:      tap_mask = 24'hE10000;
            default: tap_mask = 24'h000000;
        endcase
    endfunction

    localparam int unsigned NAT_N   = (mode == 0) ? (32'd1 << inbits) : ((32'd1 << inbits) - 32'd1);
    localparam int unsigned NVEC    = (count == 0) ? NAT_N : count;
    localparam int unsigned CNT_MAX = (NVEC > latency) ? NVEC : latency;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [inbits-1:0] TAPS   = inbits'(tap_mask(inbits));
    localparam logic [inbits-1:0] SEED_V = inbits'(seed);
    localparam logic [inbits-1:0] FIRST  = (mode == 0) ? '0 :
                                           ((SEED_V == '0) ? inbits'(1) : SEED_V);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [inbits-1:0]   comp_in_q, comp_in_d, step_c;
    logic [errbits-1:0]  err_q, err_d;
    logic [inbits-1:0]   fail_q, fail_d;
    logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic                cmp_vld_c, mism_c, stop_c;
    logic [outbits-1:0]  cmp_exp_c;
    logic [inbits-1:0]   cmp_stim_c;

    assign comp_in   = comp_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_in   = fail_q;

    // Expected-value source: live reference, or a latency-deep delay line of (verify, stimulus).
    generate
        if (latency == 0) begin : g_comb
            always_comb begin
                cmp_vld_c  = (state_q == ST_RUN);
                cmp_exp_c  = verify;
                cmp_stim_c = comp_in_q;
            end
        end else begin : g_pipe
            logic [latency-1:0] vld_q;
            logic [outbits-1:0] exp_q  [latency];
            logic [inbits-1:0]  stim_q [latency];

            // Valid bits die on stop, on run completion and on reset.
            always_ff @(posedge clk) begin
                if (rst || !((state_d == ST_RUN) || (state_d == ST_DRAIN))) begin
                    vld_q <= '0;
                end else begin
                    vld_q <= latency'({vld_q, (state_q == ST_RUN)});
                end
            end

            always_ff @(posedge clk) begin
                exp_q[0]  <= verify;
                stim_q[0] <= comp_in_q;
                for (int unsigned i = 1; i < latency; i++) begin
                    exp_q[i]  <= exp_q[i-1];
                    stim_q[i] <= stim_q[i-1];
                end
            end

            always_comb begin
                cmp_vld_c  = vld_q[latency-1];
                cmp_exp_c  = exp_q[latency-1];
                cmp_stim_c = stim_q[latency-1];
            end
        end
    endgenerate

    // X/Z on the DUT output must count as a mismatch, hence the case inequality.
    assign mism_c = cmp_vld_c && (comp_out !== cmp_exp_c);
    assign stop_c = mism_c && (stop_on_fail != 0);

    always_comb begin
        if (mode == 0) step_c = comp_in_q + inbits'(1);
        else           step_c = (comp_in_q >> 1) ^ (comp_in_q[0] ? TAPS : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (stop_c)                     state_d = ST_DONE;
                else if (cnt_q == CNT_W'(1))    state_d = (latency > 0) ? ST_DRAIN : ST_DONE;
            end
            ST_DRAIN: if (stop_c || (cnt_q == CNT_W'(1))) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (err_d == '0);
    end

    // Vector counter doubles as the drain counter once the last vector has been issued.
    always_comb begin
        cnt_d     = cnt_q;
        comp_in_d = comp_in_q;
        err_d     = err_q;
        fail_d    = fail_q;
        if (((state_q == ST_IDLE) || (state_q == ST_DONE)) && start) begin
            cnt_d     = CNT_W'(NVEC);
            comp_in_d = FIRST;
            err_d     = '0;
            fail_d    = '0;
        end else begin
            if (state_q == ST_RUN) begin
                if (state_d == ST_RUN) begin
                    cnt_d     = cnt_q - CNT_W'(1);
                    comp_in_d = step_c;
                end else if (state_d == ST_DRAIN) begin
                    cnt_d = CNT_W'(latency);
                end
            end else if (state_q == ST_DRAIN) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            if (mism_c) begin
                if (err_q != '1) err_d = err_q + errbits'(1);
                if (err_q == '0) fail_d = cmp_stim_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            comp_in_q <= '0;
            err_q     <= '0;
            fail_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            comp_in_q <= comp_in_d;
            err_q     <= err_d;
            fail_q    <= fail_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            if ((verbose != 0) && mism_c) begin
                $display("%s: mismatch at stimulus %h, expected %h, got %h",
                         name, cmp_stim_c, cmp_exp_c, comp_out);
            end
        end
    end

endmodule

// File: tb/tb_seqtest.sv
// Bench for seqtest: four harness instances with small behavioural DUTs (some with a planted
// wrong answer), a queue of expected comp_in values and end-of-run results per instance.
module tb_seqtest;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start;
    logic [3:0] busy_w, done_w, pass_w;
    logic [2:0] cin0, ver0, out0, fail0;
    logic [3:0] cin1, fail1;
    logic [2:0] ver1, out1, r1a, r1b;
    logic [3:0] cin2, ver2, out2, fail2;
    logic [3:0] cin3, ver3, out3, r3, fail3;
    logic [15:0] err0, err1, err2, err3;

    logic [3:0] flt_en;
    int         flt_val [4];

    // Small DUTs: the reference is correct, the DUT flips bit 0 at the planted input.
    assign ver0 = ~cin0;
    assign out0 = ~cin0 ^ {2'b00, (flt_en[0] && (cin0 == 3'(flt_val[0])))};
    assign ver1 = 3'(cin1[3:2]) + 3'(cin1[1:0]);
    always @(posedge clk) begin
        r1a <= (3'(cin1[3:2]) + 3'(cin1[1:0])) ^ {2'b00, (flt_en[1] && (cin1 == 4'(flt_val[1])))};
        r1b <= r1a;
    end
    assign out1 = r1b;
    assign ver2 = cin2 ^ 4'hA;
    assign out2 = ver2 ^ {3'b000, (flt_en[2] && (cin2 == 4'(flt_val[2])))};
    assign ver3 = ~cin3;
    always @(posedge clk) r3 <= ~cin3 ^ {3'b000, (flt_en[3] && (cin3 == 4'(flt_val[3])))};
    assign out3 = r3;

    seqtest #(.name("u0"), .inbits(3), .outbits(3), .latency(0), .mode(0), .stop_on_fail(0)) u0 (
        .clk(clk), .rst(rst), .start(start), .comp_in(cin0), .verify(ver0), .comp_out(out0),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(err0), .fail_in(fail0));
    seqtest #(.name("u1"), .inbits(4), .outbits(3), .latency(2), .mode(0), .stop_on_fail(0)) u1 (
        .clk(clk), .rst(rst), .start(start), .comp_in(cin1), .verify(ver1), .comp_out(out1),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(err1), .fail_in(fail1));
    seqtest #(.name("u2"), .inbits(4), .outbits(4), .latency(0), .mode(0), .stop_on_fail(1)) u2 (
        .clk(clk), .rst(rst), .start(start), .comp_in(cin2), .verify(ver2), .comp_out(out2),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_count(err2), .fail_in(fail2));
    seqtest #(.name("u3"), .inbits(4), .outbits(4), .latency(1), .mode(1), .seed(0),
              .stop_on_fail(0)) u3 (
        .clk(clk), .rst(rst), .start(start), .comp_in(cin3), .verify(ver3), .comp_out(out3),
        .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]), .err_count(err3), .fail_in(fail3));

    logic [31:0] cin_a [4];
    logic [31:0] err_a [4];
    logic [31:0] fail_a [4];
    always_comb begin
        cin_a[0] = 32'(cin0); cin_a[1] = 32'(cin1); cin_a[2] = 32'(cin2); cin_a[3] = 32'(cin3);
        err_a[0] = 32'(err0); err_a[1] = 32'(err1); err_a[2] = 32'(err2); err_a[3] = 32'(err3);
        fail_a[0] = 32'(fail0); fail_a[1] = 32'(fail1);
        fail_a[2] = 32'(fail2); fail_a[3] = 32'(fail3);
    end

    typedef struct {
        int busy_cyc;
        int err;
        int fail;
        int pas;
        int cin;      // -1: must equal the last value seen while busy
    } res_t;

    int   exp_vec [4][$];
    res_t exp_res [4][$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) $display("FAIL %s u%0d: got %0h, want %0h", nm, k, act, want);
        else              n_pass++;
    endtask

    // Exhaustive run model: vector at position i is i; a stop lands latency cycles after the bad one.
    task automatic push_exh(input int k, input int ib, input int lat, input bit stop);
        int   n, idx, b;
        res_t r;
        n   = 1 << ib;
        idx = flt_en[k] ? flt_val[k] : -1;
        b   = (stop && idx >= 0) ? idx + 1 + lat : n + lat;
        for (int c = 1; c <= b; c++) exp_vec[k].push_back((c - 1 < n) ? c - 1 : n - 1);
        r.busy_cyc = b;
        r.err      = (idx >= 0) ? 1 : 0;
        r.fail     = (idx >= 0) ? idx : 0;
        r.pas      = (idx >= 0) ? 0 : 1;
        r.cin      = (b - 1 < n) ? b - 1 : n - 1;
        exp_res[k].push_back(r);
    endtask

    // LFSR run: every nonzero value appears once, then one drain cycle.
    task automatic push_lfsr(input int k);
        res_t r;
        r.busy_cyc = 16;
        r.err      = flt_en[k] ? 1 : 0;
        r.fail     = flt_en[k] ? flt_val[k] : 0;
        r.pas      = flt_en[k] ? 0 : 1;
        r.cin      = -1;
        exp_res[k].push_back(r);
    endtask

    // Monitor: compares comp_in every busy cycle, and the final results when done rises.
    int          bcnt [4];
    logic [3:0]  done_prev, busy_prev;
    logic [15:0] seen3;
    logic [31:0] prev3;
    initial begin
        for (int k = 0; k < 4; k++) bcnt[k] = 0;
        done_prev = '0; busy_prev = '0; seen3 = '0; prev3 = '0;
    end

    always @(negedge clk) begin
        res_t r;
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                exp_vec[k].delete();
                exp_res[k].delete();
                bcnt[k] = 0;
                if (k == 3) seen3 = '0;
            end else begin
                if (busy_w[k]) begin
                    bcnt[k]++;
                    if (k == 3) begin
                        if (bcnt[k] == 1)
                            chk("lfsr_first", k, cin_a[3], 32'd1);
                        else if (bcnt[k] <= 15)
                            chk("lfsr_fresh", k, 32'((cin_a[3] != 0) && !seen3[cin_a[3][3:0]]), 32'd1);
                        else
                            chk("lfsr_hold", k, cin_a[3], prev3);
                        seen3[cin_a[3][3:0]] = 1'b1;
                        prev3 = cin_a[3];
                    end else if (exp_vec[k].size() == 0) begin
                        chk("extra_busy_cycle", k, 32'd0, 32'd1);
                    end else begin
                        chk("comp_in", k, cin_a[k], 32'(exp_vec[k].pop_front()));
                    end
                end
                if (done_w[k] && !done_prev[k]) begin
                    chk("done_follows_busy", k, 32'(busy_prev[k]), 32'd1);
                    if (exp_res[k].size() == 0) begin
                        chk("unexpected_done", k, 32'd0, 32'd1);
                    end else begin
                        r = exp_res[k].pop_front();
                        chk("busy_cycles", k, 32'(bcnt[k]), 32'(r.busy_cyc));
                        chk("err_count", k, err_a[k], 32'(r.err));
                        chk("fail_in", k, fail_a[k], 32'(r.fail));
                        chk("pass", k, 32'(pass_w[k]), 32'(r.pas));
                        chk("final_comp_in", k, cin_a[k], (r.cin < 0) ? prev3 : 32'(r.cin));
                        chk("vectors_left", k, 32'(exp_vec[k].size()), 32'd0);
                    end
                    bcnt[k] = 0;
                    if (k == 3) seen3 = '0;
                end
            end
            done_prev[k] = done_w[k];
            busy_prev[k] = busy_w[k];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        for (int k = 0; k < 4; k++) begin
            chk("rst_busy", k, 32'(busy_w[k]), 32'd0);
            chk("rst_done", k, 32'(done_w[k]), 32'd0);
            chk("rst_pass", k, 32'(pass_w[k]), 32'd0);
            chk("rst_err", k, err_a[k], 32'd0);
            chk("rst_fail", k, fail_a[k], 32'd0);
            chk("rst_comp_in", k, cin_a[k], 32'd0);
        end
    endtask

    task automatic push_all();
        push_exh(0, 3, 0, 1'b0);
        push_exh(1, 4, 2, 1'b0);
        push_exh(2, 4, 0, 1'b1);
        push_lfsr(3);
    endtask

    task automatic run_round(input bit restart_mid);
        push_all();
        start = 1'b1; tick(); start = 1'b0;
        if (restart_mid) begin
            tick(); tick();
            start = 1'b1; tick(); start = 1'b0;
        end
        for (int c = 0; c < 100 && done_w != 4'hF; c++) tick();
        chk("all_done", -1, 32'(done_w), 32'hF);
        tick(); tick();
        repeat ($urandom_range(0, 3)) tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flt_en = '0;
        for (int k = 0; k < 4; k++) flt_val[k] = 0;
        repeat (3) tick();
        check_reset();
        rst = 1'b0;
        tick();

        run_round(1'b0);

        flt_en = 4'hF;
        flt_val[0] = int'($urandom_range(0, 7));
        flt_val[1] = 5;
        flt_val[2] = 5;
        flt_val[3] = int'($urandom_range(1, 15));
        run_round(1'b1);

        for (int r = 0; r < 4; r++) begin
            flt_en = 4'($urandom_range(0, 15));
            flt_val[0] = int'($urandom_range(0, 7));
            flt_val[1] = int'($urandom_range(0, 15));
            flt_val[2] = int'($urandom_range(0, 15));
            flt_val[3] = int'($urandom_range(1, 15));
            run_round(1'b0);
        end

        // Abort in the third RUN cycle, then hold start together with rst.
        flt_en = '0;
        push_all();
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        rst = 1'b1; tick();
        check_reset();
        start = 1'b1; tick();
        chk("rst_beats_start", -1, 32'(busy_w), 32'd0);
        rst = 1'b0; start = 1'b0;
        tick();
        run_round(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
